// File: rtl/uart_word_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx_if
// Description : Push-side handshake between the chip buffer FSM (master) and
//               the UART word transmitter (slave). One 16-bit word per
//               tx_vld pulse; tx_done tells the pusher the word has left the
//               pin. busy and err_ovr are status back to the pusher.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_word_tx_if;

  logic [15:0] tx_data;   // word to send, sampled DATA_DLY cycles after tx_vld
  logic        tx_vld;    // single-cycle send request
  logic        tx_done;   // single-cycle pulse after the last stop bit
  logic        busy;      // a word is in flight
  logic        err_ovr;   // sticky: a request arrived while busy

  // Pusher side: drives the word and the request, watches status.
  modport master (
    output tx_data,
    output tx_vld,
    input  tx_done,
    input  busy,
    input  err_ovr
  );

  // Transmitter side: consumes the word and the request, reports status.
  modport slave (
    input  tx_data,
    input  tx_vld,
    output tx_done,
    output busy,
    output err_ovr
  );

endinterface : uart_word_tx_if
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx
// Description : Sends one 16-bit word per tx_vld pulse on the UART line as two
//               serial bytes, high byte first, LSB first within each byte.
//               Default frame is 8N1 (20 bit times per word). Defining the
//               macro UART_PARITY_EN adds an even-parity bit to each byte
//               (8E1, 22 bit times per word).
//               Runs entirely in the clk_sys domain.
// Parameters  : BAUD_DIV - clk_sys cycles per UART bit, 2..65535
//               DATA_DLY - cycles from tx_vld to the valid tx_data sample
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx #(
  parameter int BAUD_DIV = 434,
  parameter int DATA_DLY = 1
) (
  input  wire logic         clk_sys,
  input  wire logic         rst,
  uart_word_tx_if.slave     push,
  output logic              uart_txd
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Every bit period starts by loading this value and ends when the count
  // reaches zero, so each bit lasts exactly BAUD_DIV cycles.
  localparam logic [15:0] BAUD_LOAD  = 16'(BAUD_DIV - 1);

  // S_CAP dwells DATA_DLY cycles; the counter loads DATA_DLY-1 on entry and
  // the sample is taken in the cycle it reads zero.
  localparam logic [15:0] DLY_LOAD   = (DATA_DLY > 0) ? 16'(DATA_DLY - 1) : 16'd0;

  // With DATA_DLY = 0 the word is already valid alongside tx_vld, so the
  // capture happens in the accepting cycle and S_CAP is never visited.
  localparam bit          CAP_BYPASS = (DATA_DLY == 0);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CAP   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd6;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]  state_q,    state_d;
  logic [15:0] baud_q,     baud_d;      // bit-period down-counter
  logic [2:0]  bit_q,      bit_d;       // data bit index inside the byte
  logic        byte_sel_q, byte_sel_d;  // 0 = high byte, 1 = low byte
  logic [15:0] shreg_q,    shreg_d;     // word held for the whole frame
  logic [15:0] dly_q,      dly_d;       // S_CAP dwell counter
  logic        txd_q,      txd_d;       // registered line driver
  logic        ovr_q,      ovr_d;       // sticky overrun flag

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  logic [7:0] w_cur_byte;
  logic [2:0] w_bit_nxt;
  logic       w_baud_end;
  logic       w_can_accept;

  assign w_cur_byte   = byte_sel_q ? shreg_q[7:0] : shreg_q[15:8];
  assign w_bit_nxt    = bit_q + 3'd1;    // wraps 7 -> 0 at the end of a byte
  assign w_baud_end   = (baud_q == 16'd0);
  // The S_DONE cycle also accepts a word so consecutive words leave no idle
  // bit between them.
  assign w_can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

  // Next-state, counter and line-value logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    shreg_d    = shreg_q;
    dly_d      = dly_q;
    txd_d      = txd_q;
    ovr_d      = ovr_q;

    // A request while a frame is in progress is dropped; the frame itself is
    // left untouched and only the sticky flag records the event.
    if (push.tx_vld && !w_can_accept) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        txd_d = 1'b1;
        if (push.tx_vld) begin
          if (CAP_BYPASS) begin
            shreg_d    = push.tx_data;
            byte_sel_d = 1'b0;
            baud_d     = BAUD_LOAD;
            txd_d      = 1'b0;
            state_d    = S_START;
          end else begin
            dly_d      = DLY_LOAD;
            state_d    = S_CAP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CAP: begin
        if (dly_q == 16'd0) begin
          shreg_d    = push.tx_data;
          byte_sel_d = 1'b0;
          baud_d     = BAUD_LOAD;
          txd_d      = 1'b0;
          state_d    = S_START;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end

      S_START: begin
        if (w_baud_end) begin
          bit_d   = 3'd0;
          baud_d  = BAUD_LOAD;
          txd_d   = w_cur_byte[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          bit_d  = w_bit_nxt;
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            // Even parity: the bit makes the count of ones in 9 bits even.
            txd_d   = ^w_cur_byte;
            state_d = S_PAR;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            txd_d = w_cur_byte[w_bit_nxt];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

`ifdef UART_PARITY_EN
      S_PAR: begin
        if (w_baud_end) begin
          baud_d  = BAUD_LOAD;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif

      S_STOP: begin
        if (w_baud_end) begin
          byte_sel_d = ~byte_sel_q;
          if (!byte_sel_q) begin
            // High byte finished: the low byte's start bit follows directly.
            baud_d  = BAUD_LOAD;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            txd_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all sequencer state; reset abandons any frame in flight.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
      byte_sel_q <= 1'b0;
      shreg_q    <= 16'd0;
      dly_q      <= 16'd0;
      txd_q      <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      shreg_q    <= shreg_d;
      dly_q      <= dly_d;
      txd_q      <= txd_d;
      ovr_q      <= ovr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registers, so the pin and the status are
  // glitch-free.
  // --------------------------------------------------------------------------
  assign uart_txd     = txd_q;
  assign push.tx_done = (state_q == S_DONE);
  assign push.busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign push.err_ovr = ovr_q;

endmodule : uart_word_tx
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_tx
// Description : Self-checking bench for uart_word_tx (BAUD_DIV=4, DATA_DLY=1).
//               A timing model derived from the frame rules predicts the line,
//               busy, tx_done and err_ovr every cycle; a line decoder recovers
//               the bytes for the directed scenarios. Honours UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

  localparam int BAUD = 4;
  localparam int DLY  = 1;
`ifdef UART_PARITY_EN
  localparam int BPB  = 11;   // start + 8 data + parity + stop
  localparam int LAT  = 90;
`else
  localparam int BPB  = 10;   // start + 8 data + stop
  localparam int LAT  = 82;
`endif
  localparam int DONE_K = DLY + 1 + 2 * BPB * BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_txd;
  int   cyc = 0;

  uart_word_tx_if bus ();

  uart_word_tx #(.BAUD_DIV(BAUD), .DATA_DLY(DLY)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .push    (bus.slave),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk    = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Line value of frame bit idx (0 .. 2*BPB-1) for word w.
  function automatic logic frame_bit(input logic [15:0] w, input int idx);
    int         j;
    logic [7:0] by;
    j  = idx % BPB;
    by = (idx / BPB == 0) ? w[15:8] : w[7:0];
    if (j == 0) return 1'b0;
    if (j <= 8) return by[j-1];
`ifdef UART_PARITY_EN
    if (j == 9) return ^by;
`endif
    return 1'b1;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_act  = 0;
  int          m_T    = 0;
  logic [15:0] m_word = '0;
  bit          m_ovr  = 0;
  bit          primed = 0;

  initial begin : model
    forever begin
      @(negedge clk);
      if (primed) begin : cmp
        logic e_txd, e_busy, e_done;
        int   k;
        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (m_act) begin
          k = cyc - m_T;
          if (k <= DLY) e_busy = 1'b1;
          else if (k < DONE_K) begin
            e_busy = 1'b1;
            e_txd  = frame_bit(m_word, (k - DLY - 1) / BAUD);
          end else e_done = 1'b1;
        end
        check("uart_txd", uart_txd,     e_txd);
        check("busy",     bus.busy,     e_busy);
        check("tx_done",  bus.tx_done,  e_done);
        check("err_ovr",  bus.err_ovr,  m_ovr);
        if (bus.tx_done) done_cnt++;
      end
      // Advance with the inputs the coming edge will sample.
      if (rst) begin
        m_act = 0; m_ovr = 0; primed = 1;
      end else if (primed) begin : adv
        bit in_done;
        in_done = m_act && (cyc - m_T == DONE_K);
        if (bus.tx_vld) begin
          if (!m_act || in_done) begin m_act = 1; m_T = cyc; end
          else m_ovr = 1;
        end else if (in_done) m_act = 0;
        if (m_act && (cyc - m_T == DLY)) m_word = bus.tx_data;
      end
    end
  end

  // ---------------- UART line decoder ----------------
  logic [7:0] q_b[$];
`ifdef UART_PARITY_EN
  logic       q_p[$];
`endif

  initial begin : dec
    bit         act;
    int         s, off, i;
    logic       prev;
    logic [7:0] sh;
    logic       par;
    act = 0; s = 0; prev = 1'b1; sh = '0; par = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !primed) begin
        act = 0; prev = 1'b1;
      end else begin
        if (!act && prev && !uart_txd) begin act = 1; s = cyc; end
        if (act) begin
          off = cyc - s;
          if (off % BAUD == BAUD / 2) begin
            i = off / BAUD;
            if (i == 0) check("dec_start", uart_txd, 1'b0);
            else if (i <= 8) sh[i-1] = uart_txd;
            else if (i == BPB - 1) begin
              check("dec_stop", uart_txd, 1'b1);
              q_b.push_back(sh);
`ifdef UART_PARITY_EN
              q_p.push_back(par);
`endif
              act = 0;
            end else par = uart_txd;
          end
        end
        prev = uart_txd;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) next_cyc();
  endtask

  // Request in the current cycle, word valid in the following one.
  task automatic send(input logic [15:0] w, output int t);
    t = cyc;
    bus.tx_vld = 1'b1; bus.tx_data = 16'($urandom);
    next_cyc();
    bus.tx_vld = 1'b0; bus.tx_data = w;
    next_cyc();
    bus.tx_data = 16'($urandom);
  endtask

  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int n = 0; n < max; n++) begin
      if (bus.tx_done) begin at = cyc; break; end
      next_cyc();
    end
    if (at < 0) check("tx_done_timeout", 32'(at), 32'(cyc));
  endtask

  task automatic expect_bytes(input string nm, input logic [7:0] e0, input logic [7:0] e1);
    check({nm, "_count"}, 32'(q_b.size()), 32'd2);
    check({nm, "_hi"}, (q_b.size() > 0) ? q_b[0] : 8'hxx, e0);
    check({nm, "_lo"}, (q_b.size() > 1) ? q_b[1] : 8'hxx, e1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int T, at, d0, mode;
    bus.tx_vld = 1'b0; bus.tx_data = '0; rst = 1'b1;

    // 1: reset held for three cycles
    repeat (3) begin
      next_cyc();
      check("rst_txd",  uart_txd,    1'b1);
      check("rst_done", bus.tx_done, 1'b0);
      check("rst_busy", bus.busy,    1'b0);
      check("rst_ovr",  bus.err_ovr, 1'b0);
    end
    rst = 1'b0;
    repeat (2) next_cyc();

    // 2: single word 0xA55A, pinned latencies
    q_b.delete();
    T = cyc;
    bus.tx_vld = 1'b1; bus.tx_data = 16'($urandom);
    next_cyc();
    check("t2_busy_cap", bus.busy, 1'b1);
    check("t2_idle_cap", uart_txd, 1'b1);
    bus.tx_vld = 1'b0; bus.tx_data = 16'hA55A;
    next_cyc();
    check("t2_start_edge", uart_txd, 1'b0);
    bus.tx_data = 16'($urandom);
    wait_done(200, at);
    check("t2_done_lat", 32'(at - T), 32'(LAT));
    expect_bytes("t2_bytes", 8'hA5, 8'h5A);

    // 3: ten words back to back, one cycle after each tx_done
    q_b.delete();
    for (int w = 1; w <= 10; w++) begin
      next_cyc();
      send(16'(w), T);
      wait_done(200, at);
    end
    check("t3_count", 32'(q_b.size()), 32'd20);
    for (int j = 0; j < 20; j++)
      check("t3_byte", (j < q_b.size()) ? q_b[j] : 8'hxx, (j % 2 == 0) ? 8'h00 : 8'(j / 2 + 1));
    check("t3_ovr", bus.err_ovr, 1'b0);

    // 4: overrun 20 cycles into a frame
    next_cyc();
    q_b.delete();
    d0 = done_cnt;
    send(16'h3C96, T);
    goto(T + 20);
    check("t4_ovr_before", bus.err_ovr, 1'b0);
    bus.tx_vld = 1'b1; bus.tx_data = 16'hFFFF;
    next_cyc();
    bus.tx_vld = 1'b0;
    check("t4_ovr_set", bus.err_ovr, 1'b1);
    wait_done(200, at);
    repeat (100) next_cyc();
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t4_ovr_sticky", bus.err_ovr, 1'b1);
    expect_bytes("t4_bytes", 8'h3C, 8'h96);

    // 5: reset 30 cycles into a frame, then a fresh word
    q_b.delete();
    send(16'h1234, T);
    goto(T + 30);
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    check("t5_txd",  uart_txd,    1'b1);
    check("t5_busy", bus.busy,    1'b0);
    check("t5_ovr",  bus.err_ovr, 1'b0);
    d0 = done_cnt;
    repeat (120) next_cyc();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    q_b.delete();
    send(16'h00FF, T);
    wait_done(200, at);
    check("t5_done_lat", 32'(at - T), 32'(LAT));
    expect_bytes("t5_bytes", 8'h00, 8'hFF);

`ifdef UART_PARITY_EN
    // 6: parity on 0x0700
    next_cyc();
    q_b.delete(); q_p.delete();
    send(16'h0700, T);
    wait_done(200, at);
    check("t6_done_lat", 32'(at - T), 32'd90);
    expect_bytes("t6_bytes", 8'h07, 8'h00);
    check("t6_par_hi", (q_p.size() > 0) ? q_p[0] : 1'bx, 1'b1);
    check("t6_par_lo", (q_p.size() > 1) ? q_p[1] : 1'bx, 1'b0);
`endif

    // Random words: accept-in-done, varied gaps, occasional overruns.
    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 2);
      if (mode == 1) next_cyc();
      else if (mode == 2) repeat ($urandom_range(2, 6)) next_cyc();
      send(16'($urandom), T);
      if ($urandom_range(0, 3) == 0) begin
        goto(T + $urandom_range(3, 60));
        bus.tx_vld = 1'b1; bus.tx_data = 16'($urandom);
        next_cyc();
        bus.tx_vld = 1'b0;
      end
      wait_done(200, at);
    end

    repeat (10) next_cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_uart_word_tx
`default_nettype wire
